// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle signed/unsigned magnitude comparator.
// Computes a - b one CHUNK-bit slice per cycle (LSB first) using a single
// narrow adder, then derives lt/eq and the selected op result (LT/LE/EQ/NE).
// Optional macro COMPARATOR_SEQ_BACK_TO_BACK_EN lets a new transaction be
// accepted on the same edge the previous result is taken.
module comparator_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    input  logic [1:0]   op,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         out,
    output logic         lt,
    output logic         eq
);

    localparam int BEATS = N / CHUNK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   opA_q;
    logic [N-1:0]   opNotB_q;
    logic           isSigned_q;
    logic [1:0]     opSel_q;
    logic           carry_q;
    logic           nonzero_q;
    logic [BW-1:0]  beat_q;
    logic           oValid_q;
    logic           out_q;
    logic           lt_q;
    logic           eq_q;

    logic [CHUNK:0] sliceSum;
    logic           nonzero_d;
    logic           eq_d;
    logic           lt_d;
    logic           out_d;
    logic           sumMsb;
    logic           aMsb;
    logic           bMsb;
    logic           overflow;
    logic           accept;

    // One adder slice: current low chunk of A plus low chunk of ~B plus carry.
    // The operand registers shift right each beat, so the active chunk is
    // always at bit 0 and the final beat sees the operand MSBs at CHUNK-1.
    always_comb begin
        sliceSum  = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, opNotB_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        nonzero_d = nonzero_q | (|sliceSum[CHUNK-1:0]);
        eq_d      = ~nonzero_d;
        sumMsb    = sliceSum[CHUNK-1];
        aMsb      = opA_q[CHUNK-1];
        bMsb      = ~opNotB_q[CHUNK-1];
        overflow  = (aMsb ^ bMsb) & (sumMsb ^ aMsb);
        lt_d      = isSigned_q ? (sumMsb ^ overflow) : ~sliceSum[CHUNK];
        out_d     = 1'b0;
        case (opSel_q)
            2'b00:   out_d = lt_d;
            2'b01:   out_d = lt_d | eq_d;
            2'b10:   out_d = eq_d;
            default: out_d = ~eq_d;
        endcase
    end

`ifdef COMPARATOR_SEQ_BACK_TO_BACK_EN
    assign i_ready = (state_q == IDLE) || ((state_q == DONE) && o_ready);
`else
    assign i_ready = (state_q == IDLE);
`endif

    assign accept  = i_valid && i_ready;
    assign o_valid = oValid_q;
    assign out     = out_q;
    assign lt      = lt_q;
    assign eq      = eq_q;

    // Control FSM plus datapath registers; a new capture overrides the
    // DONE->IDLE return when a result is taken and new operands arrive together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opNotB_q   <= '0;
            isSigned_q <= 1'b0;
            opSel_q    <= 2'b00;
            carry_q    <= 1'b0;
            nonzero_q  <= 1'b0;
            beat_q     <= '0;
            oValid_q   <= 1'b0;
            out_q      <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                BUSY: begin
                    opA_q     <= opA_q >> CHUNK;
                    opNotB_q  <= opNotB_q >> CHUNK;
                    carry_q   <= sliceSum[CHUNK];
                    nonzero_q <= nonzero_d;
                    beat_q    <= beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_q  <= DONE;
                        oValid_q <= 1'b1;
                        out_q    <= out_d;
                        lt_q     <= lt_d;
                        eq_q     <= eq_d;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        oValid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                opA_q      <= a;
                opNotB_q   <= ~b;
                isSigned_q <= is_signed;
                opSel_q    <= op;
                carry_q    <= 1'b1;
                nonzero_q  <= 1'b0;
                beat_q     <= '0;
                state_q    <= BUSY;
            end
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// tb_comparator_seq: directed tests for comparator_seq (N=32, CHUNK=8).
// Expected values are hand-computed per vector.
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic [1:0]  op;
    logic        o_valid;
    logic        o_ready;
    logic        out;
    logic        lt;
    logic        eq;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_LT = 2'b00;
    localparam logic [1:0] OP_LE = 2'b01;
    localparam logic [1:0] OP_EQ = 2'b10;
    localparam logic [1:0] OP_NE = 2'b11;

    comparator_seq #(.N(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .op        (op),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .out       (out),
        .lt        (lt),
        .eq        (eq)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Launch one transaction from an idle DUT, scramble the inputs after
    // capture, and wait (bounded) for o_valid; lat counts cycles after accept.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sg, input logic [1:0] o,
                                 output int lat);
        @(negedge clk);
        a = av; b = bv; is_signed = sg; op = o; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; a = ~av; b = ~bv; op = ~o;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Take the pending result with a one-cycle o_ready pulse.
    task automatic consume;
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid got %b expected 0", o_valid); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_i_ready got %b expected 1", i_ready); end
        checks++; if ({out, lt, eq} !== 3'b000) begin errors++; $display("[TB] FAIL reset_outputs got %b expected 000", {out, lt, eq}); end
        rst = 1'b0;
    endtask

    task automatic test_signed_lt;
        int lat;
        applyStimulus(32'hFFFF_FFFB, 32'd3, 1'b1, OP_LT, lat);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL signed_lt_latency got %0d expected 4", lat); end
        checks++; if (out !== 1'b1) begin errors++; $display("[TB] FAIL signed_lt_out got %b expected 1", out); end
        checks++; if (lt !== 1'b1) begin errors++; $display("[TB] FAIL signed_lt_lt got %b expected 1", lt); end
        checks++; if (eq !== 1'b0) begin errors++; $display("[TB] FAIL signed_lt_eq got %b expected 0", eq); end
        consume();
    endtask

    task automatic test_unsigned_lt;
        int lat;
        applyStimulus(32'hFFFF_FFFB, 32'd3, 1'b0, OP_LT, lat);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL unsigned_big_valid got %b expected 1", o_valid); end
        checks++; if ({out, lt} !== 2'b00) begin errors++; $display("[TB] FAIL unsigned_big_lt got %b expected 00", {out, lt}); end
        consume();
        applyStimulus(32'd3, 32'hFFFF_FFFB, 1'b0, OP_LT, lat);
        checks++; if ({out, lt} !== 2'b11) begin errors++; $display("[TB] FAIL unsigned_small_lt got %b expected 11", {out, lt}); end
        consume();
    endtask

    task automatic test_overflow;
        int lat;
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, OP_LE, lat);
        checks++; if ({out, lt, eq} !== 3'b110) begin errors++; $display("[TB] FAIL overflow_le got %b expected 110", {out, lt, eq}); end
        consume();
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, OP_LE, lat);
        checks++; if ({out, lt, eq} !== 3'b000) begin errors++; $display("[TB] FAIL overflow_swap_le got %b expected 000", {out, lt, eq}); end
        consume();
    endtask

    task automatic test_eq_ne;
        int lat;
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, OP_EQ, lat);
        checks++; if ({out, lt, eq} !== 3'b101) begin errors++; $display("[TB] FAIL eq_equal got %b expected 101", {out, lt, eq}); end
        consume();
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, OP_NE, lat);
        checks++; if ({out, eq} !== 2'b01) begin errors++; $display("[TB] FAIL ne_equal got %b expected 01", {out, eq}); end
        consume();
        applyStimulus(32'h1234_5678, 32'h1234_5679, 1'b1, OP_EQ, lat);
        checks++; if ({out, lt, eq} !== 3'b010) begin errors++; $display("[TB] FAIL eq_flip got %b expected 010", {out, lt, eq}); end
        consume();
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, OP_LE, lat);
        checks++; if ({out, lt, eq} !== 3'b101) begin errors++; $display("[TB] FAIL unsigned_equal_le got %b expected 101", {out, lt, eq}); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad = 0;
        applyStimulus(32'd1, 32'd2, 1'b1, OP_LT, lat);
        for (int i = 0; i < 5; i++) begin
            if (o_valid !== 1'b1 || out !== 1'b1 || i_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL backpressure_hold got %0d bad cycles expected 0", bad); end
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL backpressure_release got %b expected 0", o_valid); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL backpressure_idle_ready got %b expected 1", i_ready); end
    endtask

    task automatic test_reset_midop;
        int stale = 0;
        @(negedge clk);
        a = 32'd1; b = 32'd9; is_signed = 1'b1; op = OP_LT; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_reset_valid got %b expected 0", o_valid); end
        checks++; if (i_ready !== 1'b1) begin errors++; $display("[TB] FAIL midop_reset_ready got %b expected 1", i_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL midop_stale got %0d valid cycles expected 0", stale); end
    endtask

    // Three transactions with o_ready and i_valid held high; cycle count from
    // first accept to last transfer is 15 with back-to-back, else 17.
    task automatic test_back_to_back;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vs [3];
        logic [1:0]  vo [3];
        logic        vexp [3];
        int sent = 0;
        int got = 0;
        int firstAcc = -1;
        int lastXfer = -1;
        int expCycles;
        va[0] = 32'd1;         vb[0] = 32'd2; vs[0] = 1'b1; vo[0] = OP_LT; vexp[0] = 1'b1;
        va[1] = 32'd5;         vb[1] = 32'd5; vs[1] = 1'b1; vo[1] = OP_EQ; vexp[1] = 1'b1;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'd0; vs[2] = 1'b0; vo[2] = OP_LT; vexp[2] = 1'b0;
`ifdef COMPARATOR_SEQ_BACK_TO_BACK_EN
        expCycles = 15;
`else
        expCycles = 17;
`endif
        @(negedge clk);
        o_ready = 1'b1;
        a = va[0]; b = vb[0]; is_signed = vs[0]; op = vo[0]; i_valid = 1'b1;
        for (int t = 0; t < 60 && got < 3; t++) begin
            if (o_valid === 1'b1) begin
                checks++; if (out !== vexp[got]) begin errors++; $display("[TB] FAIL b2b_result%0d got %b expected %b", got, out, vexp[got]); end
                got++;
                lastXfer = t;
            end
            if (i_valid === 1'b1 && i_ready === 1'b1) begin
                if (firstAcc < 0) firstAcc = t;
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
            if (sent < 3) begin
                a = va[sent]; b = vb[sent]; is_signed = vs[sent]; op = vo[sent];
            end else begin
                i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 3", got); end
        checks++; if (lastXfer - firstAcc !== expCycles) begin errors++; $display("[TB] FAIL b2b_cycles got %0d expected %0d", lastXfer - firstAcc, expCycles); end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; op = OP_LT;
        test_reset();
        test_signed_lt();
        test_unsigned_lt();
        test_overflow();
        test_eq_ne();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
